// File: rtl/lcd_fmt_pkg.sv
// Shared definitions for the LCD number formatter: FSM encoding, ASCII constants,
// the conversion cycle count and the nibble-to-hex-ASCII helper.
package lcd_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [7:0]   ASCII_SPACE = 8'h20;
    localparam logic [7:0]   ASCII_ZERO  = 8'h30;
    localparam logic [7:0]   ASCII_A     = 8'h41;
    localparam int           CONV_CYCLES = 16;
    localparam logic [47:0]  HEX_PREFIX  = "HEX 0x";
    localparam logic [127:0] BLANK_LINE  = {16{ASCII_SPACE}};

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_ZERO + {4'd0, nib};
        else
            return ASCII_A + {4'd0, nib - 4'd10};
    endfunction

endpackage

// File: rtl/lcd_bin2bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble), one input bit
// per clock after start; done is high during the final shift cycle.
module lcd_bin2bcd
    import lcd_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    localparam logic [4:0] LAST_STEP = 5'(CONV_CYCLES - 1);

    logic [15:0] shreg;
    logic [4:0]  cnt;
    logic        busy;
    logic [19:0] bcd_adj;

    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch for the untouched path.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 5; d++) begin
            if (bcd[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    assign done = busy && (cnt == LAST_STEP);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            bcd   <= {bcd_adj[18:0], shreg[15]};
            shreg <= {shreg[14:0], 1'b0};
            cnt   <= cnt + 5'd1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_num_formatter.sv
// Formats a 16-bit value into two 16-char LCD rows (decimal and hex), committing both
// rows atomically. Define LCD_FMT_LEADING_ZERO_BLANK_EN to blank leading decimal zeros.
module lcd_num_formatter
    import lcd_fmt_pkg::*;
#(
    parameter logic [63:0] LABEL = "VALUE:  "
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [15:0]  in_value,
    output logic         in_ready,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic         upd
);

    state_t       state, state_nxt;
    logic         accept;
    logic         conv_done;
    logic [15:0]  value;
    logic [19:0]  bcd;
    logic [39:0]  dec_ascii;
    logic [127:0] line1_nxt, line2_nxt;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    lcd_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .bin   (in_value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept)    state_nxt = ST_CONV;
            ST_CONV:   if (conv_done) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

`ifdef LCD_FMT_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic lead;
        lead      = 1'b1;
        dec_ascii = '0;
        for (int d = 4; d >= 1; d--) begin
            if (lead && (bcd[4*d +: 4] == 4'd0)) begin
                dec_ascii[8*d +: 8] = ASCII_SPACE;
            end else begin
                lead                = 1'b0;
                dec_ascii[8*d +: 8] = ASCII_ZERO + {4'd0, bcd[4*d +: 4]};
            end
        end
        // The units digit is always shown so zero reads as "    0".
        dec_ascii[7:0] = ASCII_ZERO + {4'd0, bcd[3:0]};
    end
`else
    always_comb begin
        dec_ascii = '0;
        for (int d = 0; d < 5; d++)
            dec_ascii[8*d +: 8] = ASCII_ZERO + {4'd0, bcd[4*d +: 4]};
    end
`endif

    assign line1_nxt = {LABEL, dec_ascii, {3{ASCII_SPACE}}};
    assign line2_nxt = {HEX_PREFIX,
                        hex_ascii(value[15:12]), hex_ascii(value[11:8]),
                        hex_ascii(value[7:4]),   hex_ascii(value[3:0]),
                        {6{ASCII_SPACE}}};

    // Rows only change in COMMIT so the LCD driver never sees half-converted text.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            line1 <= BLANK_LINE;
            line2 <= BLANK_LINE;
            upd   <= 1'b0;
        end else begin
            upd <= (state == ST_COMMIT);
            if (accept)
                value <= in_value;
            if (state == ST_COMMIT) begin
                line1 <= line1_nxt;
                line2 <= line2_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Directed self-checking bench for lcd_num_formatter; expected rows are hand-written
// literals, with decimal rows chosen by LCD_FMT_LEADING_ZERO_BLANK_EN.
module tb_lcd_num_formatter;

    localparam logic [127:0] BLANK    = {16{8'h20}};
    localparam logic [127:0] L1_12345 = "VALUE:  12345   ";
    localparam logic [127:0] L1_65535 = "VALUE:  65535   ";
    localparam logic [127:0] L1_10000 = "VALUE:  10000   ";
`ifdef LCD_FMT_LEADING_ZERO_BLANK_EN
    localparam logic [127:0] L1_0     = "VALUE:      0   ";
    localparam logic [127:0] L1_100   = "VALUE:    100   ";
    localparam logic [127:0] L1_200   = "VALUE:    200   ";
    localparam logic [127:0] L1_300   = "VALUE:    300   ";
`else
    localparam logic [127:0] L1_0     = "VALUE:  00000   ";
    localparam logic [127:0] L1_100   = "VALUE:  00100   ";
    localparam logic [127:0] L1_200   = "VALUE:  00200   ";
    localparam logic [127:0] L1_300   = "VALUE:  00300   ";
`endif
    localparam logic [127:0] L2_3039  = "HEX 0x3039      ";
    localparam logic [127:0] L2_0000  = "HEX 0x0000      ";
    localparam logic [127:0] L2_FFFF  = "HEX 0xFFFF      ";
    localparam logic [127:0] L2_2710  = "HEX 0x2710      ";
    localparam logic [127:0] L2_0064  = "HEX 0x0064      ";
    localparam logic [127:0] L2_00C8  = "HEX 0x00C8      ";
    localparam logic [127:0] L2_012C  = "HEX 0x012C      ";

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [15:0]  in_value;
    logic         in_ready;
    logic [127:0] line1, line2;
    logic         upd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_num_formatter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_value (in_value),
        .in_ready (in_ready),
        .line1    (line1),
        .line2    (line2),
        .upd      (upd)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one value for exactly one accept edge, then wait to the commit edge.
    task automatic convert(input logic [15:0] v);
        in_value = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (16) tick();
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        #12;
        check("rst_ready", in_ready, 1'b1);
        check("rst_upd",   upd,      1'b0);
        check("rst_line1", line1,    BLANK);
        check("rst_line2", line2,    BLANK);
        tick();
        rst_n = 1'b1;
        tick();

        // 12345 with cycle-by-cycle observation of the CONV window
        in_value = 16'd12345;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_busy_ready", in_ready, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t1_conv_upd",   upd,   1'b0);
            check("t1_conv_line1", line1, BLANK);
            check("t1_conv_line2", line2, BLANK);
        end
        tick();
        check("t1_upd",   upd,      1'b1);
        check("t1_line1", line1,    L1_12345);
        check("t1_line2", line2,    L2_3039);
        check("t1_ready", in_ready, 1'b1);
        tick();
        check("t1_upd_off", upd,   1'b0);
        check("t1_hold1",   line1, L1_12345);
        check("t1_hold2",   line2, L2_3039);

        // zero
        convert(16'd0);
        check("t2_upd",   upd,   1'b1);
        check("t2_line1", line1, L1_0);
        check("t2_line2", line2, L2_0000);
        tick();

        // 10000
        convert(16'd10000);
        check("t3_upd",   upd,   1'b1);
        check("t3_line1", line1, L1_10000);
        check("t3_line2", line2, L2_2710);
        tick();

        // 65535 accepted, 7 offered throughout CONV must be ignored
        in_value = 16'd65535;
        in_valid = 1'b1;
        tick();
        in_value = 16'd7;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("t4_upd",   upd,      (k == 17));
            check("t4_ready", in_ready, (k == 17));
        end
        in_valid = 1'b0;
        check("t4_line1", line1, L1_65535);
        check("t4_line2", line2, L2_FFFF);
        tick();
        check("t4_single_upd", upd,      1'b0);
        check("t4_hold1",      line1,    L1_65535);
        check("t4_ready_idle", in_ready, 1'b1);

        // reset in CONV cycle 8 of 999
        in_value = 16'd999;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_line1", line1,    BLANK);
        check("t5_rst_line2", line2,    BLANK);
        check("t5_rst_upd",   upd,      1'b0);
        check("t5_rst_ready", in_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("t5_no_upd", upd, 1'b0);
        end
        check("t5_line1", line1,    BLANK);
        check("t5_line2", line2,    BLANK);
        check("t5_ready", in_ready, 1'b1);

        // in_valid held high with 100, 200, 300: accepts 18 cycles apart
        in_value = 16'd100;
        in_valid = 1'b1;
        tick();
        in_value = 16'd200;
        for (int k = 1; k <= 56; k++) begin
            tick();
            check("t6_upd",   upd,      (k == 17 || k == 35 || k == 53));
            check("t6_ready", in_ready, (k == 17 || k == 35 || k >= 53));
            if (k < 17)       check("t6_line1", line1, BLANK);
            else if (k < 35)  check("t6_line1", line1, L1_100);
            else if (k < 53)  check("t6_line1", line1, L1_200);
            else              check("t6_line1", line1, L1_300);
            if (k == 17) check("t6_line2_a", line2, L2_0064);
            if (k == 35) check("t6_line2_b", line2, L2_00C8);
            if (k == 53) check("t6_line2_c", line2, L2_012C);
            if (k == 18) in_value = 16'd300;
            if (k == 36) in_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
